// File: rtl/sine_synth_mc_if.sv
// Control and sample-stream bundle for sine_synth_mc.
// The master side (controller/bench) drives the strobes and frequency
// writes; the slave side (the synthesiser) returns the sample stream and
// the busy/overrun status.
interface sine_synth_mc_if #(
  parameter int CH_W    = 2,
  parameter int PHASE_W = 32,
  parameter int OUT_W   = 16
);
  logic                      en;
  logic                      sample_tick;
  logic                      freq_we;
  logic [CH_W-1:0]           freq_ch;
  logic [PHASE_W-1:0]        freq_word;
  logic                      phase_clr;
  logic                      overrun_clr;
  logic                      out_valid;
  logic [CH_W-1:0]           out_ch;
  logic signed [OUT_W-1:0]   out_data;
  logic                      busy;
  logic                      overrun;

  modport master (
    output en, sample_tick, freq_we, freq_ch, freq_word, phase_clr, overrun_clr,
    input  out_valid, out_ch, out_data, busy, overrun
  );

  modport slave (
    input  en, sample_tick, freq_we, freq_ch, freq_word, phase_clr, overrun_clr,
    output out_valid, out_ch, out_data, busy, overrun
  );
endinterface

// File: rtl/sine_synth_mc.sv
// Multi-channel quarter-wave sine synthesiser.
// NUM_CH phase accumulators share one quarter-wave ROM; each accepted
// sample_tick issues channels 0..NUM_CH-1 on consecutive cycles through a
// three-stage pipeline (address, ROM read, negate/output).
// Optional feature: define SINE_SYNTH_DITHER_EN to add LFSR phase dither.
module sine_synth_mc #(
  parameter int NUM_CH  = 4,
  parameter int PHASE_W = 32,
  parameter int LUT_AW  = 9,
  parameter int OUT_W   = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  sine_synth_mc_if.slave bus
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int LUT_N = 1 << LUT_AW;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  // Elaboration-time sine of the half-step sample point, rounded; a plain
  // Taylor series keeps the ROM contents independent of tool math libraries.
  function automatic int lut_entry(input int i);
    real x, term, s, amp;
    x    = 3.141592653589793 / 2.0 * (real'(i) + 0.5) / real'(LUT_N);
    term = x;
    s    = x;
    for (int n = 1; n < 10; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      s    = s + term;
    end
    amp = real'((1 << (OUT_W - 1)) - 1);
    return $rtoi(amp * s + 0.5);
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state_reg, state_next;
  logic [CH_W-1:0]     ch_reg, ch_next;
  logic                issue;
  logic                tick_drop;

  logic [PHASE_W-1:0]  acc_vec [NUM_CH];
  logic [PHASE_W-1:0]  acc_sel;
  logic [PHASE_W-1:0]  issue_phase;
  logic                unused_phase;
  logic                ph_sign, ph_dir;
  logic [LUT_AW-1:0]   ph_index, ph_addr;

  logic                s0_valid, s0_sign;
  logic [CH_W-1:0]     s0_ch;
  logic [LUT_AW-1:0]   s0_addr;
  logic                s1_valid, s1_sign;
  logic [CH_W-1:0]     s1_ch;
  logic [OUT_W-1:0]    rom_q;
  logic                out_valid_reg;
  logic [CH_W-1:0]     out_ch_reg;
  logic [OUT_W-1:0]    out_data_reg;
  logic                overrun_reg;

  logic [OUT_W-1:0]    rom [LUT_N];

  for (genvar gi = 0; gi < LUT_N; gi++) begin : rom_gen
    localparam logic [OUT_W-1:0] ENTRY = OUT_W'(lut_entry(gi));
    assign rom[gi] = ENTRY;
  end

  // Per-channel frequency word and phase accumulator.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : ch_gen
    logic [PHASE_W-1:0] acc_reg, freq_reg;

    // Frequency writes land any time; clear beats the issue-time accumulate.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_reg  <= '0;
        freq_reg <= '0;
      end else begin
        if (bus.freq_we && bus.freq_ch == CH_W'(gi))
          freq_reg <= bus.freq_word;
        if (bus.phase_clr)
          acc_reg <= '0;
        else if (issue && ch_reg == CH_W'(gi))
          acc_reg <= acc_reg + freq_reg;
      end
    end

    assign acc_vec[gi] = acc_reg;
  end

  assign acc_sel = acc_vec[ch_reg];

`ifdef SINE_SYNTH_DITHER_EN
  localparam int FRAC_W = PHASE_W - 2 - LUT_AW;
  localparam int DITH_W = (FRAC_W < 16) ? FRAC_W : 16;
  logic [15:0] lfsr_reg;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, one step per issued channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lfsr_reg <= 16'hACE1;
    else if (issue)
      lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
  end

  if (DITH_W > 0) begin : dith_gen
    assign issue_phase = acc_sel + PHASE_W'(lfsr_reg[DITH_W-1:0]);
  end else begin : nodith_gen
    assign issue_phase = acc_sel;
  end
`else
  assign issue_phase = acc_sel;
`endif

  // Bits below the LUT index are truncated by design.
  assign unused_phase = ^issue_phase;
  assign ph_sign  = issue_phase[PHASE_W-1];
  assign ph_dir   = issue_phase[PHASE_W-2];
  assign ph_index = issue_phase[PHASE_W-3 -: LUT_AW];
  assign ph_addr  = ph_dir ? ~ph_index : ph_index;

  assign tick_drop = bus.en && bus.sample_tick && (state_reg != IDLE);

  // FSM state and channel counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ch_reg    <= '0;
    end else begin
      state_reg <= state_next;
      ch_reg    <= ch_next;
    end
  end

  // Channel 0 issues on the accepting edge; DRAIN waits for S0/S1 to empty.
  always_comb begin
    state_next = state_reg;
    ch_next    = ch_reg;
    issue      = 1'b0;
    case (state_reg)
      IDLE, RUN: begin
        if (state_reg == RUN || (bus.en && bus.sample_tick)) begin
          issue = 1'b1;
          if (ch_reg == LAST_CH) begin
            state_next = DRAIN;
            ch_next    = '0;
          end else begin
            state_next = RUN;
            ch_next    = ch_reg + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!s0_valid && !s1_valid)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // S0: register the folded ROM address and sign.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid <= 1'b0;
      s0_sign  <= 1'b0;
      s0_ch    <= '0;
      s0_addr  <= '0;
    end else begin
      s0_valid <= issue;
      s0_sign  <= ph_sign;
      s0_ch    <= ch_reg;
      s0_addr  <= ph_addr;
    end
  end

  // S1 control: carry channel and sign alongside the ROM read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_ch    <= '0;
    end else begin
      s1_valid <= s0_valid;
      s1_sign  <= s0_sign;
      s1_ch    <= s0_ch;
    end
  end

  // S1 data: synchronous ROM read, left unreset so it maps to block memory.
  always_ff @(posedge clk) begin
    rom_q <= rom[s0_addr];
  end

  // S2: negate into the output register; data and channel hold between samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_ch_reg    <= '0;
      out_data_reg  <= '0;
    end else begin
      out_valid_reg <= s1_valid;
      if (s1_valid) begin
        out_ch_reg   <= s1_ch;
        out_data_reg <= s1_sign ? -rom_q : rom_q;
      end
    end
  end

  // Sticky overrun: a dropped tick wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overrun_reg <= 1'b0;
    else if (tick_drop)
      overrun_reg <= 1'b1;
    else if (bus.overrun_clr)
      overrun_reg <= 1'b0;
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_ch    = out_ch_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.busy      = (state_reg != IDLE);
  assign bus.overrun   = overrun_reg;
endmodule

// File: tb/tb_sine_synth_mc.sv
// Self-checking bench for sine_synth_mc: directed scenarios followed by
// randomized frames, checked against a full-circle sine reference model.
module tb_sine_synth_mc;
  localparam int NUM_CH  = 4;
  localparam int PHASE_W = 32;
  localparam int LUT_AW  = 9;
  localparam int OUT_W   = 16;
  localparam int CH_W    = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sine_synth_mc_if #(.CH_W(CH_W), .PHASE_W(PHASE_W), .OUT_W(OUT_W)) bus ();

  sine_synth_mc #(
    .NUM_CH(NUM_CH), .PHASE_W(PHASE_W), .LUT_AW(LUT_AW), .OUT_W(OUT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  int frame_no = 0;

  // Reference state
  logic [PHASE_W-1:0] m_acc  [NUM_CH];
  logic [PHASE_W-1:0] m_freq [NUM_CH];
  int                 last_data;
  int                 last_ch;
  bit                 m_ovr;
  int                 got_s  [NUM_CH];

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Sine sampled at the half-step point of the truncated full-circle phase.
  function automatic int ref_sample(input logic [PHASE_W-1:0] p);
    int  q;
    real a, v;
    q = int'(p >> (PHASE_W - 2 - LUT_AW));
    a = 2.0 * 3.141592653589793 * (real'(q) + 0.5) / real'(4 << LUT_AW);
    v = 32767.0 * $sin(a);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(-v + 0.5);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      m_acc[k]  = '0;
      m_freq[k] = '0;
    end
    last_data = 0;
    last_ch   = 0;
    m_ovr     = 1'b0;
  endtask

  task automatic write_freq(input int ch, input logic [PHASE_W-1:0] w);
    bus.freq_we   = 1'b1;
    bus.freq_ch   = CH_W'(ch);
    bus.freq_word = w;
    step();
    bus.freq_we   = 1'b0;
    m_freq[ch]    = w;
    $display("write freq[%0d]=%08h", ch, w);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check("idle_valid", bus.out_valid, 0);
      check("idle_busy", bus.busy, 0);
      check("idle_overrun", bus.overrun, m_ovr);
    end
  endtask

  // One frame starting from an idle observation point. An optional extra
  // tick (with chosen en) and overrun_clr can be driven at observation m.
  task automatic run_frame(input int extra_m, input bit extra_en, input int clr_m);
    int  exp_s [NUM_CH];
    int  k;
    bit  ev, drop, clr;
    for (int c = 0; c < NUM_CH; c++) begin
      exp_s[c] = ref_sample(m_acc[c]);
      m_acc[c] = m_acc[c] + m_freq[c];
    end
    bus.en          = 1'b1;
    bus.sample_tick = 1'b1;
    step();
    for (int m = 0; m <= 2 + NUM_CH; m++) begin
      ev = (m >= 2) && (m < 2 + NUM_CH);
      k  = m - 2;
      check("busy", bus.busy, (m <= 1 + NUM_CH) ? 1 : 0);
      check("out_valid", bus.out_valid, ev ? 1 : 0);
      check("overrun", bus.overrun, m_ovr);
      if (ev) begin
        got_s[k]  = int'($signed(bus.out_data));
        last_data = exp_s[k];
        last_ch   = k;
      end
      check("out_ch", bus.out_ch, last_ch);
      check("out_data", $signed(bus.out_data), last_data);
      if (m == 2 + NUM_CH) begin
        bus.sample_tick = 1'b0;
        bus.en          = 1'b1;
        bus.overrun_clr = 1'b0;
        break;
      end
      drop = (m == extra_m) && extra_en;
      clr  = (m == clr_m);
      bus.sample_tick = (m == extra_m);
      bus.en          = (m == extra_m) ? extra_en : 1'b1;
      bus.overrun_clr = clr;
      if (drop) m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
      step();
    end
    $display("frame %0d: %0d %0d %0d %0d ovr=%0d", frame_no,
             got_s[0], got_s[1], got_s[2], got_s[3], bus.overrun);
    frame_no++;
  endtask

  int tab0 [4] = '{50, 32767, -50, -32767};
  int tab2 [4] = '{50, -50, 50, -50};

  initial begin
    int act;
    logic [PHASE_W-1:0] w;
    bus.en = 1'b1; bus.sample_tick = 1'b0; bus.freq_we = 1'b0;
    bus.freq_ch = '0; bus.freq_word = '0; bus.phase_clr = 1'b0;
    bus.overrun_clr = 1'b0;
    rst_n = 1'b0;
    model_reset();
    step(); step();
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", $signed(bus.out_data), 0);
    check("rst_ch", bus.out_ch, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_overrun", bus.overrun, 0);
    rst_n = 1'b1;
    idle(2);

    // Quadrant points and half-rate channel, back-to-back at max rate
    write_freq(0, 32'h4000_0000);
    write_freq(2, 32'h8000_0000);
    for (int f = 0; f < 4; f++) begin
      run_frame(-1, 1'b0, -1);
      check("quad_ch0", got_s[0], tab0[f]);
      check("half_ch2", got_s[2], tab2[f]);
    end

    // Overrun: tick at T+2 dropped, sticky, cleared
    run_frame(1, 1'b1, -1);
    idle(2);
    bus.overrun_clr = 1'b1; step(); bus.overrun_clr = 1'b0; m_ovr = 1'b0;
    check("ovr_clr", bus.overrun, 0);
    run_frame(1 + NUM_CH, 1'b1, -1);     // last busy cycle still drops
    run_frame(-1, 1'b0, 0);              // clear inside a frame
    run_frame(1, 1'b0, -1);              // en=0 tick while busy: ignored
    run_frame(2, 1'b1, 2);               // set wins over same-cycle clear

    // Idle tick with en=0 is ignored
    bus.en = 1'b0; bus.sample_tick = 1'b1; step();
    bus.en = 1'b1; bus.sample_tick = 1'b0;
    check("en0_busy", bus.busy, 0);
    idle(3);

    // phase_clr returns channels to phase 0
    write_freq(1, 32'h1000_0000);
    for (int f = 0; f < 3; f++) run_frame(-1, 1'b0, -1);
    bus.phase_clr = 1'b1; step(); bus.phase_clr = 1'b0;
    for (int c = 0; c < NUM_CH; c++) m_acc[c] = '0;
    run_frame(-1, 1'b0, -1);
    check("clr_ch1", got_s[1], 50);

    // Reset mid-frame aborts immediately
    bus.sample_tick = 1'b1; step(); bus.sample_tick = 1'b0;
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_data", $signed(bus.out_data), 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_overrun", bus.overrun, 0);
    step();
    rst_n = 1'b1;
    idle(NUM_CH + 3);
    run_frame(-1, 1'b0, -1);
    check("post_rst_ch3", got_s[3], 50);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      act = $urandom_range(0, 9);
      if (act < 4) begin
        case ($urandom_range(0, 3))
          0: w = 32'h4000_0000;
          1: w = PHASE_W'($urandom_range(0, 4095)) << 21;
          default: w = $urandom;
        endcase
        write_freq($urandom_range(0, NUM_CH - 1), w);
      end else if (act == 4) begin
        bus.phase_clr = 1'b1; step(); bus.phase_clr = 1'b0;
        for (int c = 0; c < NUM_CH; c++) m_acc[c] = '0;
        $display("phase_clr");
      end else if (act == 5) begin
        idle($urandom_range(1, 3));
      end
      if ($urandom_range(0, 3) == 0)
        run_frame($urandom_range(0, NUM_CH + 1), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 1) ? -1 : $urandom_range(0, NUM_CH + 1));
      else
        run_frame(-1, 1'b0, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
